// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronized rx, mid-bit sampling, valid/ack byte handshake.
// BAUD_DIV matches the transmitter: one bit period is BAUD_DIV+1 clk cycles.
module uart_rx #(
    parameter int unsigned BAUD_DIV = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       ack,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    localparam logic [15:0] CNT_FULL = 16'(BAUD_DIV);
    localparam logic [15:0] CNT_HALF = 16'(BAUD_DIV / 2);

    logic        rx_meta_q;
    logic        rx_sync_q;
    logic        rx_s;

    logic [2:0]  state_q,     state_d;
    logic [15:0] cnt_q,       cnt_d;
    logic [2:0]  bit_idx_q,   bit_idx_d;
    logic [7:0]  shift_q,     shift_d;
    logic [7:0]  data_out_q,  data_out_d;
    logic        valid_q,     valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q,   overrun_d;
    logic        busy_q,      busy_d;
    logic        done_s;

    assign rx_s = rx_sync_q;

    // Two-stage synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Frame sequencing: baud counter, bit index and shift register.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        done_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 16'd0;
                if (!rx_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = 16'd0;
                    bit_idx_d = 3'd0;
                    // A start bit that is already gone at mid-bit was only a glitch.
                    if (!rx_s) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d            = 16'd0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
                        state_d   = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d  = 16'd0;
                    done_s = 1'b1;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_WAIT_HIGH: begin
                cnt_d = 16'd0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = 16'd0;
                bit_idx_d = 3'd0;
            end
        endcase
    end

    // Output handshake: a completion outranks ack; ack only matters while valid.
    always_comb begin
        data_out_d  = data_out_q;
        valid_d     = valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        busy_d      = (state_d != ST_IDLE);
        if (done_s) begin
            data_out_d  = shift_q;
            valid_d     = 1'b1;
            frame_err_d = ~rx_s;
            overrun_d   = valid_q & ~ack;
        end else if (ack && valid_q) begin
            valid_d     = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            valid_d     = valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_out_q  <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD_DIV=15 (16 clk per bit).
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       ack;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc;

    uart_rx #(.BAUD_DIV(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .ack       (ack),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one frame starting just after a clock edge; the stop level is held stop_len clk.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len);
        rx = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(16);
        end
        rx = stop_v;
        tick(stop_len);
        rx = 1'b1;
    endtask

    task automatic wait_valid(input int bound, output int n, input string tag);
        n = 0;
        while (n < bound && valid !== 1'b1) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(valid), 32'h1);
    endtask

    task automatic pulse_ack;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        ack = 1'b0;
        tick(3);
        chk("rst_data",  32'(data_out),  32'h00);
        chk("rst_valid", 32'(valid),     32'h0);
        chk("rst_ferr",  32'(frame_err), 32'h0);
        chk("rst_ovr",   32'(overrun),   32'h0);
        chk("rst_busy",  32'(busy),      32'h0);
        rst = 1'b0;
        tick(3);

        // Single 0xA5 frame, exact latency, ack 5 clk after valid
        fork
            send_frame(8'hA5, 1'b1, 16);
            begin
                wait_valid(400, cyc, "a5_valid");
                chk("a5_latency", 32'(cyc),       32'd155);
                chk("a5_data",    32'(data_out),  32'hA5);
                chk("a5_ferr",    32'(frame_err), 32'h0);
                chk("a5_ovr",     32'(overrun),   32'h0);
                chk("a5_busy",    32'(busy),      32'h0);
                tick(4);
                chk("a5_valid_hold", 32'(valid), 32'h1);
                pulse_ack();
                chk("a5_valid_clr", 32'(valid),    32'h0);
                chk("a5_data_hold", 32'(data_out), 32'hA5);
            end
        join

        // Back-to-back 0x00 / 0xFF with ack after each
        fork
            begin
                send_frame(8'h00, 1'b1, 16);
                send_frame(8'hFF, 1'b1, 16);
            end
            begin
                wait_valid(400, cyc, "b2b_v0");
                chk("b2b_d0",    32'(data_out),  32'h00);
                chk("b2b_ferr0", 32'(frame_err), 32'h0);
                pulse_ack();
                chk("b2b_clr0",  32'(valid),     32'h0);
                wait_valid(400, cyc, "b2b_v1");
                chk("b2b_d1",    32'(data_out),  32'hFF);
                chk("b2b_ferr1", 32'(frame_err), 32'h0);
                chk("b2b_ovr1",  32'(overrun),   32'h0);
                pulse_ack();
            end
        join
        tick(2);

        // Same pair with no ack: second byte overruns the first
        send_frame(8'h00, 1'b1, 16);
        send_frame(8'hFF, 1'b1, 16);
        tick(2);
        chk("ovr_data",  32'(data_out),  32'hFF);
        chk("ovr_valid", 32'(valid),     32'h1);
        chk("ovr_flag",  32'(overrun),   32'h1);
        chk("ovr_ferr",  32'(frame_err), 32'h0);
        pulse_ack();
        chk("ovr_clr_valid", 32'(valid),   32'h0);
        chk("ovr_clr_flag",  32'(overrun), 32'h0);
        tick(2);

        // 0x3C with a 40-clk low stop bit, then 0x55
        fork
            send_frame(8'h3C, 1'b0, 40);
            begin
                wait_valid(400, cyc, "fe_valid");
                chk("fe_data", 32'(data_out),  32'h3C);
                chk("fe_flag", 32'(frame_err), 32'h1);
                tick(20);
                chk("fe_wait_busy",  32'(busy),  32'h1);
                chk("fe_wait_valid", 32'(valid), 32'h1);
            end
        join
        tick(4);
        chk("fe_idle_busy", 32'(busy), 32'h0);
        pulse_ack();
        chk("fe_clr_ferr",  32'(frame_err), 32'h0);
        chk("fe_clr_valid", 32'(valid),     32'h0);
        fork
            send_frame(8'h55, 1'b1, 16);
            begin
                wait_valid(400, cyc, "fe_next_valid");
                chk("fe_next_data", 32'(data_out),  32'h55);
                chk("fe_next_ferr", 32'(frame_err), 32'h0);
                pulse_ack();
            end
        join
        tick(2);

        // 4-clk glitch on idle line
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        chk("gl_busy_start", 32'(busy), 32'h1);
        tick(8);
        chk("gl_busy_end", 32'(busy),      32'h0);
        chk("gl_valid",    32'(valid),     32'h0);
        chk("gl_ferr",     32'(frame_err), 32'h0);
        chk("gl_ovr",      32'(overrun),   32'h0);

        // Reset during bit 4 of 0x81, then 0x42
        fork
            send_frame(8'h81, 1'b1, 16);
            begin
                tick(88);
                rst = 1'b1;
                tick(2);
                chk("mr_data",  32'(data_out),  32'h00);
                chk("mr_valid", 32'(valid),     32'h0);
                chk("mr_ferr",  32'(frame_err), 32'h0);
                chk("mr_ovr",   32'(overrun),   32'h0);
                chk("mr_busy",  32'(busy),      32'h0);
            end
        join
        rst = 1'b0;
        tick(3);
        fork
            send_frame(8'h42, 1'b1, 16);
            begin
                wait_valid(400, cyc, "mr_next_valid");
                chk("mr_next_data", 32'(data_out),  32'h42);
                chk("mr_next_ferr", 32'(frame_err), 32'h0);
                chk("mr_next_ovr",  32'(overrun),   32'h0);
                pulse_ack();
            end
        join
        tick(2);

        // Ack coincident with completion of 0x99 while an overrun is pending
        send_frame(8'h11, 1'b1, 16);
        chk("co_d11",   32'(data_out), 32'h11);
        chk("co_v11",   32'(valid),    32'h1);
        send_frame(8'h22, 1'b1, 16);
        chk("co_d22",   32'(data_out), 32'h22);
        chk("co_ovr22", 32'(overrun),  32'h1);
        fork
            send_frame(8'h99, 1'b1, 16);
            begin
                tick(154);
                chk("co_pre_data", 32'(data_out), 32'h22);
                pulse_ack();
                chk("co_valid", 32'(valid),     32'h1);
                chk("co_data",  32'(data_out),  32'h99);
                chk("co_ovr",   32'(overrun),   32'h0);
                chk("co_ferr",  32'(frame_err), 32'h0);
            end
        join
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
